// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage.
// Holds the IF/ID pipeline register, decodes the instruction fields, owns the
// 32x32 register file (write-back port with same-cycle bypass), and raises a
// stall request to fetch on a load-use hazard.
// Ports:
//   CLK, RST (async, active-low)
//   Ins, nextPC            fetched instruction and its PC+4
//   flush                  squash the instruction being latched
//   ex_memread, ex_rt      load currently in EX and its destination
//   wb_we, wb_addr, wb_data  register-file write-back port
//   stall                  hold request to fetch (combinational)
//   id_valid, id_pc        IF/ID register status and latched PC+4
//   opcode..jtarget        decoded fields (combinational from IF/ID)
//   rs_data, rt_data       register reads after write-back bypass
module id_stage #(
  parameter int unsigned RF_DEPTH = 32,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] nextPC,
  input  logic        flush,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [31:0] imm_zext,
  output logic [31:0] jtarget,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic [DW-1:0] id_ins;
  logic [DW-1:0] rf [RF_DEPTH];
  logic          uses_rt;
  logic          hazard;

  // IF/ID pipeline register: flush beats stall beats normal latch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      id_ins   <= NOP_INS;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_ins   <= NOP_INS;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_ins   <= Ins;
      id_pc    <= nextPC;
      id_valid <= 1'b1;
    end
  end

  // Register file write port; r0 is never written, independent of stall/flush
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_we && (wb_addr != AW'(0))) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Field decode
  assign opcode   = id_ins[31:26];
  assign rs       = id_ins[25:21];
  assign rt       = id_ins[20:16];
  assign rd       = id_ins[15:11];
  assign shamt    = id_ins[10:6];
  assign funct    = id_ins[5:0];
  assign imm_sext = {{16{id_ins[15]}}, id_ins[15:0]};
  assign imm_zext = {16'h0000, id_ins[15:0]};
  assign jtarget  = {id_pc[31:28], id_ins[25:0], 2'b00};

  // Reads with write-through bypass so a same-cycle write-back is visible
  assign rs_data = (rs == AW'(0))                 ? '0      :
                   (wb_we && (wb_addr == rs))     ? wb_data :
                                                    rf[rs];
  assign rt_data = (rt == AW'(0))                 ? '0      :
                   (wb_we && (wb_addr == rt))     ? wb_data :
                                                    rf[rt];

  // Opcodes whose rt field is a source operand (R-type, beq, bne, sw)
  always_comb begin
    uses_rt = 1'b0;
    case (opcode)
      6'h00, 6'h04, 6'h05, 6'h2b: uses_rt = 1'b1;
      default:                    uses_rt = 1'b0;
    endcase
  end

  // Load-use hazard; a flush squashes the consumer so no stall is needed
  assign hazard = id_valid & ex_memread & (ex_rt != AW'(0)) &
                  ((ex_rt == rs) | (uses_rt & (ex_rt == rt)));
  assign stall  = hazard & ~flush;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage. A driver applies one input
// vector per cycle at the falling edge and pushes the expected outputs
// (from a behavioural model of the stage); a monitor pops and compares them
// a few time units later, still well before the next rising edge.
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] Ins = '0;
  logic [31:0] nextPC = '0;
  logic        flush = 1'b0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rt = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        stall, id_valid;
  logic [31:0] id_pc, imm_sext, imm_zext, jtarget, rs_data, rt_data;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;

  id_stage dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .nextPC(nextPC), .flush(flush),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .id_valid(id_valid), .id_pc(id_pc), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm_sext(imm_sext),
    .imm_zext(imm_zext), .jtarget(jtarget), .rs_data(rs_data),
    .rt_data(rt_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] op, rs, rt, rd, sh, fn;
    logic [31:0] sext, zext, jt, rsd, rtd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state
  logic        m_valid = 1'b0;
  logic [31:0] m_ins   = '0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_rf [32];

  task automatic check(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a,
      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && (32'(wa) == a)) return wd;
    return m_rf[a];
  endfunction

  // One cycle: drive inputs, predict outputs before the next edge, advance model
  task automatic step(input string nm, input logic rst, input logic [31:0] ins,
      input logic [31:0] pc, input logic fl, input logic mr, input logic [4:0] er,
      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    logic [31:0] op, rsn, rtn, imm;
    logic        use_rt, haz;
    @(negedge CLK);
    RST = rst; Ins = ins; nextPC = pc; flush = fl; ex_memread = mr;
    ex_rt = er; wb_we = we; wb_addr = wa; wb_data = wd;
    if (!rst) begin
      m_valid = 1'b0; m_ins = '0; m_pc = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end
    op  = m_ins / 32'h0400_0000;
    rsn = (m_ins / 32'h0020_0000) % 32;
    rtn = (m_ins / 32'h0001_0000) % 32;
    imm = m_ins % 32'h0001_0000;
    use_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    haz = m_valid && mr && (er != 0) &&
          ((32'(er) == rsn) || (use_rt && (32'(er) == rtn)));
    e.nm    = nm;
    e.stall = haz && !fl;
    e.valid = m_valid;
    e.pc    = m_pc;
    e.op    = op;
    e.rs    = rsn;
    e.rt    = rtn;
    e.rd    = (m_ins / 32'h800) % 32;
    e.sh    = (m_ins / 64) % 32;
    e.fn    = m_ins % 64;
    e.zext  = imm;
    e.sext  = (imm >= 32'h8000) ? imm + 32'hFFFF_0000 : imm;
    e.jt    = (m_pc & 32'hF000_0000) + (m_ins % 32'h0400_0000) * 4;
    e.rsd   = rd_model(rsn, we, wa, wd);
    e.rtd   = rd_model(rtn, we, wa, wd);
    sb.push_back(e);
    if (rst) begin
      if (we && wa != 0) m_rf[wa] = wd;
      if (fl) begin
        m_valid = 1'b0; m_ins = '0; m_pc = '0;
      end else if (!e.stall) begin
        m_valid = 1'b1; m_ins = ins; m_pc = pc;
      end
    end
  endtask

  // Monitor: compare every expected record against the live outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.nm, "stall",    32'(stall),    32'(e.stall));
        check(e.nm, "id_valid", 32'(id_valid), 32'(e.valid));
        check(e.nm, "id_pc",    id_pc,         e.pc);
        check(e.nm, "opcode",   32'(opcode),   e.op);
        check(e.nm, "rs",       32'(rs),       e.rs);
        check(e.nm, "rt",       32'(rt),       e.rt);
        check(e.nm, "rd",       32'(rd),       e.rd);
        check(e.nm, "shamt",    32'(shamt),    e.sh);
        check(e.nm, "funct",    32'(funct),    e.fn);
        check(e.nm, "imm_sext", imm_sext,      e.sext);
        check(e.nm, "imm_zext", imm_zext,      e.zext);
        check(e.nm, "jtarget",  jtarget,       e.jt);
        check(e.nm, "rs_data",  rs_data,       e.rsd);
        check(e.nm, "rt_data",  rt_data,       e.rtd);
      end
    end
  end

  localparam logic [31:0] ADD = 32'h012A_4020;

  initial begin
    logic [31:0] ri;
    logic [4:0]  er;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    //   name         rst ins           pc            fl mr er  we wa  wd
    step("reset",      0, ADD,          32'd4,        0, 0, 0,  0, 0,  0);
    step("release",    1, ADD,          32'd4,        0, 0, 0,  0, 0,  0);
    step("bypass",     1, ADD,          32'd4,        0, 0, 0,  1, 9,  32'hDEAD_BEEF);
    step("stored",     1, ADD,          32'd4,        0, 0, 0,  0, 0,  0);
    step("r0_wr",      1, ADD,          32'd4,        0, 0, 0,  1, 0,  32'd5);
    step("r0_add",     1, 32'h0000_1020, 32'd8,       0, 0, 0,  1, 0,  32'd5);
    step("r0_read",    1, ADD,          32'd12,       0, 0, 0,  0, 0,  0);
    step("stall1",     1, 32'h1111_1111, 32'd16,      0, 1, 10, 0, 0,  0);
    step("stall2",     1, 32'h2222_2222, 32'd20,      0, 1, 10, 0, 0,  0);
    step("unstall",    1, 32'h0140_4820, 32'd24,      0, 0, 10, 0, 0,  0);
    step("ex_rt0",     1, ADD,          32'd28,       0, 1, 0,  0, 0,  0);
    step("flush_pri",  1, 32'h3333_3333, 32'd32,      1, 1, 9,  0, 0,  0);
    step("flushed",    1, 32'h2008_FFFF, 32'd36,      0, 1, 9,  0, 0,  0);
    step("imm",        1, 32'h0800_0010, 32'h4000_0004, 0, 0, 0, 0, 0, 0);
    step("jump",       1, ADD,          32'd44,       0, 0, 0,  1, 3,  32'd7);
    step("r3_ins",     1, 32'h0060_0020, 32'd48,      0, 0, 0,  0, 0,  0);
    step("r3_read",    1, ADD,          32'd52,       0, 0, 0,  0, 0,  0);
    step("r3_prep",    1, 32'h0060_0020, 32'd56,      0, 0, 0,  0, 0,  0);
    step("async_rst",  0, 32'h0060_0020, 32'd60,      0, 1, 3,  1, 3,  32'd9);
    step("rst_rel",    1, 32'h0060_0020, 32'd64,      0, 0, 0,  0, 0,  0);
    step("post_rst",   1, ADD,          32'd68,       0, 0, 0,  0, 0,  0);

    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 1) == 1) ri = (ri & 32'hFC00_FFFF) |
          (32'($urandom_range(0, 7)) << 21) | (32'($urandom_range(0, 7)) << 16);
      if ($urandom_range(0, 2) == 0) ri = ri & 32'h03FF_FFFF;
      er = 5'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 59) != 0), ri, $urandom,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), er,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
    end

    repeat (3) @(negedge CLK);
    check("drain", "pending", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly downstream of instruction fetch. Holds the IF/ID pipeline register.
- Consumes the fetched instruction word and PC+4 from fetch, and decodes the MIPS instruction fields.
- Owns the 32x32 general-purpose register file, with a write-back port and write-through bypass.
- Detects load-use hazards and drives a stall request back to fetch.

Parameters:
- RF_DEPTH, 32, number of general registers; the address width is fixed at 5.
- NOP_INS, 32'h00000000, instruction word inserted into the IF/ID register on flush and reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous and active-low. Asserted (0): all state clears immediately.
- Ins  input  32  fetched instruction word from fetch.
- nextPC  input  32  PC+4 of the fetched instruction.
- flush  input  1  branch/jump taken (the fetch redirect condition); squash the instruction being latched.
- ex_memread  input  1  the instruction in EX is a load.
- ex_rt  input  5  destination register of the load in EX.
- wb_we  input  1  write-back enable.
- wb_addr  input  5  write-back register number.
- wb_data  input  32  write-back data.
- stall  output  1  hold request to fetch (PC and IMem read must hold).
- id_valid  output  1  the IF/ID register holds a real instruction.
- id_pc  output  32  latched PC+4.
- opcode  output  6  id_ins[31:26].
- rs  output  5  id_ins[25:21].
- rt  output  5  id_ins[20:16].
- rd  output  5  id_ins[15:11].
- shamt  output  5  id_ins[10:6].
- funct  output  6  id_ins[5:0].
- imm_sext  output  32  sign-extended id_ins[15:0].
- imm_zext  output  32  zero-extended id_ins[15:0].
- jtarget  output  32  {id_pc[31:28], id_ins[25:0], 2'b00}.
- rs_data  output  32  register-file read for rs, after bypass.
- rt_data  output  32  register-file read for rt, after bypass.

Behaviour:
- Reset (RST=0, asynchronous):
  - id_ins=NOP_INS, id_pc=0, id_valid=0.
  - All RF_DEPTH registers = 0.
  - Consequently all decode outputs = 0, rs_data = rt_data = 0, stall = 0.
  - Reset asserted mid-operation discards any in-flight instruction and any same-cycle write-back.
- IF/ID register update on posedge CLK, in priority order:
  - flush=1: id_ins<=NOP_INS, id_pc<=0, id_valid<=0.
  - else stall=1: hold id_ins, id_pc, id_valid.
  - else: id_ins<=Ins, id_pc<=nextPC, id_valid<=1.
- Decode outputs are combinational from the IF/ID register only, giving one cycle of latency from fetch to decode.
- uses_rt=1 when opcode is one of: 6'h00 (R-type), 6'h04 (beq), 6'h05 (bne), 6'h2b (sw). Otherwise uses_rt=0.
- Hazard:
  - hazard = id_valid & ex_memread & (ex_rt!=0) & ((ex_rt==rs) | (uses_rt & ex_rt==rt)).
  - stall = hazard & ~flush. Combinational; flush wins when both are active.
- A stall lasts exactly as long as the condition holds. EX drains one bubble per stall cycle; this block does not insert the bubble itself.
- Register file:
  - Write on posedge when wb_we=1 and wb_addr!=0.
  - Writes to r0 are ignored. Writes are unaffected by stall and flush.
- Reads (combinational, identical for rs and rt):
  - Address 0 returns 0.
  - Else if wb_we=1 and wb_addr equals the read address, return wb_data (same-cycle bypass).
  - Else return the stored value.
- Width rules:
  - imm_sext replicates bit 15 into bits 31:16.
  - jtarget takes its top nibble from id_pc, not from the PC of the jump itself.

Test Plan:
- Reset, then release: drive Ins=32'h012A4020 (add $8,$9,$10), nextPC=4, one clock.
  -> opcode=0, rs=9, rt=10, rd=8, funct=6'h20, id_pc=4, id_valid=1, stall=0.
- Write-back bypass:
  - wb_we=1, wb_addr=9, wb_data=32'hDEADBEEF with add $8,$9,$10 in ID -> rs_data=DEADBEEF in the same cycle, before the edge.
  - After the edge with wb_we=0 -> rs_data still DEADBEEF.
  - wb_addr=0 with data 5 -> reads of r0 stay 0.
- Load-use stall:
  - ID holds add $8,$9,$10; ex_memread=1, ex_rt=10 -> stall=1; IF/ID holds across 2 clocks while Ins changes.
  - Drop ex_memread -> next edge latches the new Ins.
  - ex_rt=0 -> stall=0.
- Flush priority: stall condition active plus flush=1 -> stall=0; after the edge id_valid=0, id_ins=0, opcode=0.
- Immediates and jump:
  - Ins=32'h2008FFFF (addi $8,$0,-1) -> imm_sext=FFFFFFFF, imm_zext=0000FFFF.
  - Ins=32'h08000010 with nextPC=32'h40000004 -> jtarget=32'h40000040.
- Asynchronous reset mid-stream: load r3=7, then pull RST low between edges -> rs_data for r3 = 0, id_valid=0, stall=0 immediately, without waiting for a clock.
